rgb_led_sequencer: RTL and testbench
====================================

// Module: rgb_led_sequencer
// PURPOSE
//  Drives the on-board RGB LED and the two user LEDs from two buttons: a mode FSM
//  (OFF/SOLID/BLINK/BREATHE/CYCLE), a colour selector and an 8-bit per-channel PWM.
//  Replaces raw counter-bit LED drive with debounced, sequenced, dimmable control.
//  Sits directly between board pins (btn, led, led0_*) and nothing else.
// PARAMETERS
//  DEBOUNCE_CYCLES  120000  stable-input cycles to accept a button level (10 ms @ 12 MHz)
//  STEP_CYCLES      46875   sysclk cycles per animation step (256 steps ~= 1 s)
// PORTS
//  sysclk  in   1  system clock, 12 MHz; the only clock
//  rst_n   in   1  asynchronous, active-low reset
//  btn     in   2  raw async buttons, active-high; btn[1]=mode, btn[0]=colour
//  led     out  2  led[1]=mode!=OFF, led[0]=phase[7] heartbeat
//  led0_r  out  1  red channel, active-low (0 = lit)
//  led0_g  out  1  green channel, active-low
//  led0_b  out  1  blue channel, active-low
// BEHAVIOUR
//  Reset: mode=OFF, colour=0, phase=0, step_cnt=0, pwm_cnt=0, led=2'b00, led0_r/g/b=1.
//  Input: each btn bit goes through a 2-FF synchroniser, then a debouncer. The counter
//   clears on any mismatch; on reaching DEBOUNCE_CYCLES-1 the level is accepted.
//   A 1-cycle press pulse fires on a debounced 0->1; release gives no pulse.
//  Mode FSM, advanced by mode press: OFF->SOLID->BLINK->BREATHE->CYCLE->OFF.
//   Any mode change clears phase and step_cnt in the same cycle.
//  Colour press: colour = (colour==6) ? 0 : colour+1. Table: 0 R, 1 G, 2 B, 3 RG,
//   4 GB, 5 RB, 6 RGB. Accepted in every mode. Simultaneous presses apply both.
//  Step timer: step_cnt counts 0..STEP_CYCLES-1; the wrap cycle asserts step_tick.
//   phase (8b) increments on step_tick and wraps 255->0.
//  Level (8b) per mode:
//   OFF 0; SOLID 255; BLINK phase[7]?0:255;
//   BREATHE triangle: phase[7] ? {~phase[6:0],1'b0} : {phase[6:0],1'b0};
//   CYCLE 255, and colour auto-advances (same wrap rule) when phase wraps 255->0.
//  Channel duty = level if the channel is in the colour's mask, else 0.
//  PWM: pwm_cnt is free-running 8b. Channel lit iff duty > pwm_cnt.
//   Duty 0 is never lit; duty 255 is lit 255/256.
//  Outputs are registered: one cycle from the compare to the pin. led0_x = ~lit_x.
//  In CYCLE, a manual colour press and the auto-advance in the same cycle advance by 1 only.
//  Reset asserted mid-pattern forces all reset values immediately (async).
//   Release is used as-is; board-level reset synchronisation is out of scope.
// STRUCTURE
//  Shared package/header led_seq_pkg:
//   mode encodings (3b): OFF=0, SOLID=1, BLINK=2, BREATHE=3, CYCLE=4
//   colour-mask table (7 x 3b {r,g,b}); NUM_COLOURS=7; PWM_BITS=8
//  Sub-module btn_debounce (sync + debounce + press pulse), instantiated twice.
//  Top holds the FSM, step timer, level mux, PWM and output registers.
// TESTING
//  Bench parameters: DEBOUNCE_CYCLES=4, STEP_CYCLES=2.
//  1 Reset: hold rst_n=0 -> led=00, led0_rgb=111; release, no buttons for 1000 cycles
//    -> outputs unchanged.
//  2 Bounce: toggle btn[1] every 2 cycles for 20 cycles, then hold 1 for 10 cycles
//    -> exactly one mode advance (OFF->SOLID), led[1]=1.
//  3 SOLID, colour 0: over 256 cycles led0_r low 255 cycles; led0_g and led0_b stay 1.
//    Then 3 colour presses -> colour 3: r and g both active, b stays 1.
//  4 BLINK: led0_r low for exactly the phase 0..127 window (256 cycles at STEP=2),
//    then high for the 128..255 window; led[0] tracks phase[7].
//  5 CYCLE: after one phase wrap, colour goes 0->1. Inject a colour press on the
//    wrap cycle -> colour advances by 1, not 2. Colour 6 wraps to 0.
//  6 Async reset mid-BREATHE: pulse rst_n low between clock edges -> outputs go to
//    reset values before the next sysclk edge; mode reads OFF.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the RGB LED sequencer: mode encodings,
// the colour-to-channel mask table and the per-mode brightness curve.
package led_seq_pkg;

  localparam int NUM_COLOURS = 7;
  localparam int PWM_BITS    = 8;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_SOLID   = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_BREATHE = 3'd3,
    MODE_CYCLE   = 3'd4
  } mode_e;

  typedef logic [2:0]          colour_t;
  typedef logic [2:0]          rgb_mask_t;
  typedef logic [PWM_BITS-1:0] level_t;

  // Entry order is colour index 6 down to 0; each entry is {r,g,b}.
  localparam logic [NUM_COLOURS-1:0][2:0] COLOUR_MASK = {
    3'b111,  // 6 RGB
    3'b101,  // 5 RB
    3'b011,  // 4 GB
    3'b110,  // 3 RG
    3'b001,  // 2 B
    3'b010,  // 1 G
    3'b100   // 0 R
  };

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:     return MODE_SOLID;
      MODE_SOLID:   return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      MODE_BREATHE: return MODE_CYCLE;
      default:      return MODE_OFF;
    endcase
  endfunction

  function automatic colour_t next_colour(input colour_t c);
    return (c == colour_t'(NUM_COLOURS - 1)) ? colour_t'(0) : c + colour_t'(1);
  endfunction

  function automatic rgb_mask_t colour_mask(input colour_t c);
    if (c < colour_t'(NUM_COLOURS)) return COLOUR_MASK[c];
    return '0;
  endfunction

  // Breathe is a triangle over one phase period: ramps up in the first half,
  // down in the second, stepping by 2 so the peak reaches 254.
  function automatic level_t mode_level(input mode_e m, input logic [7:0] phase);
    case (m)
      MODE_SOLID:   return 8'hFF;
      MODE_BLINK:   return phase[7] ? 8'h00 : 8'hFF;
      MODE_BREATHE: return phase[7] ? {~phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      MODE_CYCLE:   return 8'hFF;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input: 2-FF synchroniser, stability-counter debouncer and a
// single-cycle press pulse on an accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  assign accept = (sync_q != stable) && (cnt == CNT_MAX);

  // Any cycle where the synchronised input agrees with the accepted level
  // restarts the count, so only an uninterrupted run gets through.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_q == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign press = accept & sync_q;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Button-driven RGB LED sequencer: mode FSM, colour selector, animation
// phase timer and 8-bit per-channel PWM with registered active-low pins.
module rgb_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_CYCLES     = 46875
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  output logic [1:0] led,
  output logic       led0_r,
  output logic       led0_g,
  output logic       led0_b
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);

  mode_e               mode;
  colour_t             colour;
  logic [7:0]          phase;
  logic [STEP_W-1:0]   step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic      mode_press;
  logic      colour_press;
  logic      step_tick;
  logic      phase_wrap;
  logic      auto_advance;
  level_t    level;
  rgb_mask_t mask;
  level_t    duty_r;
  level_t    duty_g;
  level_t    duty_b;
  logic      lit_r;
  logic      lit_g;
  logic      lit_b;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .btn_raw (btn[1]),
    .press   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_colour_btn (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .btn_raw (btn[0]),
    .press   (colour_press)
  );

  // The animation clock is parked in OFF so the heartbeat stays dark.
  assign step_tick    = (mode != MODE_OFF) && (step_cnt == STEP_MAX);
  assign phase_wrap   = step_tick && (phase == 8'hFF);
  assign auto_advance = (mode == MODE_CYCLE) && phase_wrap && !mode_press;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_OFF;
      colour   <= '0;
      phase    <= '0;
      step_cnt <= '0;
    end else begin
      if (mode_press) begin
        mode     <= next_mode(mode);
        phase    <= '0;
        step_cnt <= '0;
      end else if (mode != MODE_OFF) begin
        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
        if (step_tick) phase <= phase + 8'd1;
      end
      // A manual press coinciding with the CYCLE auto-advance moves one step only.
      if (colour_press || auto_advance) colour <= next_colour(colour);
    end
  end

  assign level  = mode_level(mode, phase);
  assign mask   = colour_mask(colour);
  assign duty_r = mask[2] ? level : '0;
  assign duty_g = mask[1] ? level : '0;
  assign duty_b = mask[0] ? level : '0;
  assign lit_r  = duty_r > pwm_cnt;
  assign lit_g  = duty_g > pwm_cnt;
  assign lit_b  = duty_b > pwm_cnt;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led     <= 2'b00;
      led0_r  <= 1'b1;
      led0_g  <= 1'b1;
      led0_b  <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= {mode != MODE_OFF, phase[7]};
      led0_r  <= ~lit_r;
      led0_g  <= ~lit_g;
      led0_b  <= ~lit_b;
    end
  end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Self-checking bench for rgb_led_sequencer: a cycle-level reference model
// feeds a scoreboard, plus window-count checks of duty and colour per step.
module tb_rgb_led_sequencer;

  localparam int DB   = 4;
  localparam int STEP = 2;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] btn    = 2'b00;
  logic [1:0] led;
  logic       led0_r;
  logic       led0_g;
  logic       led0_b;

  rgb_led_sequencer #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(STEP)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .btn    (btn),
    .led    (led),
    .led0_r (led0_r),
    .led0_g (led0_g),
    .led0_b (led0_b)
  );

  always #5 sysclk = ~sysclk;

  int nCompared = 0;
  int nFailed   = 0;
  int cycleNum  = 0;

  // Reference model state
  int mS1[2], mS2[2], mLvl[2], mCnt[2];
  int mMode, mColour, mPhase, mStep, mPwm;
  logic [4:0] expQ[$];

  // Output window counters (lit = pin low)
  int litR, litG, litB, hbHigh;

  typedef struct {
    logic [1:0] press;
    int         rLit;
    int         gLit;
    int         bLit;
    logic       led1;
  } vec_t;
  vec_t vecs[8];

  task automatic checkVal(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNum);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mS1[i] = 0; mS2[i] = 0; mLvl[i] = 0; mCnt[i] = 0;
    end
    mMode = 0; mColour = 0; mPhase = 0; mStep = 0; mPwm = 0;
  endtask

  task automatic modelStep(input logic [1:0] b);
    int press[2];
    int lvl, dr, dg, db, oldMode;
    bit wrap, adv, inR, inG, inB;
    logic [4:0] o;
    for (int i = 0; i < 2; i++) begin
      press[i] = (mS2[i] == 1 && mLvl[i] == 0 && mCnt[i] == DB - 1) ? 1 : 0;
      if (mS2[i] != mLvl[i]) begin
        if (mCnt[i] == DB - 1) begin
          mLvl[i] = mS2[i];
          mCnt[i] = 0;
        end else mCnt[i]++;
      end else mCnt[i] = 0;
      mS2[i] = mS1[i];
      mS1[i] = int'(b[i]);
    end
    case (mMode)
      1: lvl = 255;
      2: lvl = (mPhase >= 128) ? 0 : 255;
      3: lvl = (mPhase >= 128) ? (127 - (mPhase - 128)) * 2 : mPhase * 2;
      4: lvl = 255;
      default: lvl = 0;
    endcase
    inR = (mColour == 0 || mColour == 3 || mColour == 5 || mColour == 6);
    inG = (mColour == 1 || mColour == 3 || mColour == 4 || mColour == 6);
    inB = (mColour == 2 || mColour == 4 || mColour == 5 || mColour == 6);
    dr = inR ? lvl : 0;
    dg = inG ? lvl : 0;
    db = inB ? lvl : 0;
    o = {mMode != 0, mPhase >= 128, !(dr > mPwm), !(dg > mPwm), !(db > mPwm)};
    mPwm = (mPwm + 1) % 256;
    oldMode = mMode;
    wrap = (mMode != 0) && (mStep == STEP - 1) && (mPhase == 255);
    if (press[1] == 1) begin
      mMode = (mMode + 1) % 5;
      mPhase = 0;
      mStep = 0;
    end else if (mMode != 0) begin
      if (mStep == STEP - 1) begin
        mStep = 0;
        mPhase = (mPhase + 1) % 256;
      end else mStep++;
    end
    adv = (press[0] == 1) || (oldMode == 4 && wrap && press[1] == 0);
    if (adv) mColour = (mColour + 1) % 7;
    expQ.push_back(o);
  endtask

  task automatic checkOutput();
    logic [4:0] exp, act;
    act = {led, led0_r, led0_g, led0_b};
    nCompared++;
    if (expQ.size() == 0) begin
      nFailed++;
      $display("[TB] FAIL scoreboard_empty: got %b, no expected value queued (cycle %0d)", act, cycleNum);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        nFailed++;
        $display("[TB] FAIL pins {led,r,g,b}: got %b, expected %b (cycle %0d)", act, exp, cycleNum);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] b);
    btn = b;
    modelStep(b);
    @(posedge sysclk);
    #1;
    cycleNum++;
    checkOutput();
    if (!led0_r) litR++;
    if (!led0_g) litG++;
    if (!led0_b) litB++;
    if (led[0])  hbHigh++;
  endtask

  task automatic measure(input int n);
    litR = 0; litG = 0; litB = 0; hbHigh = 0;
    repeat (n) applyStimulus(2'b00);
  endtask

  task automatic pressBtn(input logic [1:0] which);
    repeat (DB + 4) applyStimulus(which);
    repeat (DB + 4) applyStimulus(2'b00);
  endtask

  // Runs until the model's CYCLE-mode phase wrap edge has been applied.
  task automatic runUntilWrap(input string name);
    bit hit = 0;
    for (int i = 0; i < 1200 && !hit; i++) begin
      hit = (mMode == 4 && mPhase == 255 && mStep == STEP - 1);
      applyStimulus(2'b00);
    end
    checkVal({name, "_wrap_seen"}, int'(hit), 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 255,   0,   0, 1'b1};
    vecs[1] = '{2'b01,   0, 255,   0, 1'b1};
    vecs[2] = '{2'b01,   0,   0, 255, 1'b1};
    vecs[3] = '{2'b01, 255, 255,   0, 1'b1};
    vecs[4] = '{2'b01,   0, 255, 255, 1'b1};
    vecs[5] = '{2'b01, 255,   0, 255, 1'b1};
    vecs[6] = '{2'b01, 255, 255, 255, 1'b1};
    vecs[7] = '{2'b01, 255,   0,   0, 1'b1};

    // Reset state, then idle in OFF
    modelReset();
    repeat (3) @(posedge sysclk);
    #1;
    checkVal("reset_led", int'(led), 0);
    checkVal("reset_rgb", int'({led0_r, led0_g, led0_b}), 7);
    rst_n = 1'b1;
    repeat (1000) applyStimulus(2'b00);
    checkVal("idle_led", int'(led), 0);
    checkVal("idle_rgb", int'({led0_r, led0_g, led0_b}), 7);

    // Bouncing mode button, then a clean hold: exactly one advance
    for (int i = 0; i < 20; i++) applyStimulus({((i / 2) % 2 == 0), 1'b0});
    repeat (10) applyStimulus(2'b10);
    repeat (10) applyStimulus(2'b00);
    checkVal("bounce_led1", int'(led[1]), 1);

    // SOLID: colour table walk including 6 -> 0
    foreach (vecs[k]) begin
      if (vecs[k].press != 2'b00) pressBtn(vecs[k].press);
      measure(256);
      checkVal($sformatf("solid%0d_r", k), litR, vecs[k].rLit);
      checkVal($sformatf("solid%0d_g", k), litG, vecs[k].gLit);
      checkVal($sformatf("solid%0d_b", k), litB, vecs[k].bLit);
      checkVal($sformatf("solid%0d_led1", k), int'(led[1]), int'(vecs[k].led1));
    end

    // BLINK: half-period lit, heartbeat high for half of a full phase period
    pressBtn(2'b10);
    measure(512);
    checkVal("blink_r", litR, 255);
    checkVal("blink_g", litG, 0);
    checkVal("blink_b", litB, 0);
    checkVal("blink_hb", hbHigh, 256);

    // BREATHE, then CYCLE with auto-advance
    pressBtn(2'b10);
    repeat (600) applyStimulus(2'b00);
    pressBtn(2'b10);
    runUntilWrap("cycle1");
    repeat (4) applyStimulus(2'b00);
    measure(256);
    checkVal("cycle1_r", litR, 0);
    checkVal("cycle1_g", litG, 255);
    checkVal("cycle1_b", litB, 0);

    // Colour press landing on the wrap edge: single advance to colour 2
    begin
      bit found = 0;
      int target = 256 * STEP - 1 - (DB + 1);
      for (int i = 0; i < 1200 && !found; i++) begin
        if (mMode == 4 && mPhase * STEP + mStep == target) found = 1;
        else applyStimulus(2'b00);
      end
      checkVal("inject_align", int'(found), 1);
    end
    repeat (DB + 4) applyStimulus(2'b01);
    repeat (DB + 4) applyStimulus(2'b00);
    measure(256);
    checkVal("inject_r", litR, 0);
    checkVal("inject_g", litG, 0);
    checkVal("inject_b", litB, 255);

    // Walk through to colour 6 and the wrap back to 0
    for (int w = 0; w < 4; w++) runUntilWrap($sformatf("walk%0d", w));
    repeat (4) applyStimulus(2'b00);
    measure(256);
    checkVal("colour6_r", litR, 255);
    checkVal("colour6_g", litG, 255);
    checkVal("colour6_b", litB, 255);
    runUntilWrap("walk4");
    repeat (4) applyStimulus(2'b00);
    measure(256);
    checkVal("colour0_r", litR, 255);
    checkVal("colour0_g", litG, 0);
    checkVal("colour0_b", litB, 0);

    // CYCLE -> OFF -> SOLID -> BLINK -> BREATHE, then async reset mid-pattern
    repeat (4) pressBtn(2'b10);
    repeat (300) applyStimulus(2'b00);
    checkVal("breathe_led1", int'(led[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_led", int'(led), 0);
    checkVal("async_rgb", int'({led0_r, led0_g, led0_b}), 7);
    #1;
    rst_n = 1'b1;
    modelReset();
    expQ.delete();
    repeat (20) applyStimulus(2'b00);
    checkVal("post_reset_led1", int'(led[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
